// File: rtl/polytris_pkg.sv
// Shared types and constants for the tetromino bag generator: piece ids,
// bitmap ROM, LFSR taps, bag mask and the filler FSM encoding.
package polytris_pkg;

   typedef logic [2:0] piece_id_t;

   localparam piece_id_t PIECE_I = 3'd0;
   localparam piece_id_t PIECE_O = 3'd1;
   localparam piece_id_t PIECE_T = 3'd2;
   localparam piece_id_t PIECE_S = 3'd3;
   localparam piece_id_t PIECE_Z = 3'd4;
   localparam piece_id_t PIECE_J = 3'd5;
   localparam piece_id_t PIECE_L = 3'd6;

   localparam int NUM_PIECES = 7;

   // 4x4 bitmaps, row-major, bit 15 is the top-left cell
   localparam logic [15:0] PIECE_ROM [NUM_PIECES] = '{
      16'h0F00,  // I
      16'h0660,  // O
      16'h04E0,  // T
      16'h06C0,  // S
      16'h0C60,  // Z
      16'h08E0,  // J
      16'h02E0   // L
   };

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [6:0]  BAG_FULL  = 7'h7F;

   typedef enum logic [1:0] {
      FILL_IDLE  = 2'd0,
      FILL_PICK  = 2'd1,
      FILL_PROBE = 2'd2,
      FILL_PUSH  = 2'd3
   } fill_state_t;

   function automatic logic [15:0] piece_bitmap(input piece_id_t id);
      logic [15:0] bits;
      bits = 16'h0000;
      for (int i = 0; i < NUM_PIECES; i++) begin
         if (id == piece_id_t'(i)) bits = PIECE_ROM[i];
      end
      return bits;
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/piece_fifo.sv
// DEPTH x 3-bit synchronous preview FIFO; push and pop may share a cycle,
// with head and the entry behind it readable combinationally from storage.
module piece_fifo
   import polytris_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  piece_id_t     push_data,
   input  logic          pop,
   output piece_id_t     head_data,
   output piece_id_t     next_data,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   piece_id_t     mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr_inc;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A push into a full FIFO is only legal when the head leaves in the same cycle
   assign do_pop     = pop && (count != '0);
   assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
   assign rd_ptr_inc = ptr_inc(rd_ptr);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= rd_ptr_inc;
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];
   assign next_data = mem[rd_ptr_inc];

endmodule

// File: rtl/piece_bag_generator.sv
// 7-bag tetromino source: free-running Galois LFSR, bag filler FSM and preview FIFO.
// Optional keyboard entropy mixing into the LFSR is enabled with PIECE_ENTROPY_MIX_EN.
module piece_bag_generator
   import polytris_pkg::*;
#(
   parameter int          DEPTH = 4,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [7:0]  generator_flag,
   input  logic [7:0]  keycode,
   output logic [15:0] game_piece,
   output logic [2:0]  piece_id,
   output logic [2:0]  next_piece_id,
   output logic        piece_valid,
   output logic [7:0]  pieces_dealt,
   output logic [15:0] random_noise
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [15:0]   lfsr;
   logic [15:0]   lfsr_mix;
   logic [15:0]   lfsr_nxt;

   fill_state_t   state;
   fill_state_t   state_nxt;
   piece_id_t     idx;
   piece_id_t     idx_nxt;
   logic [6:0]    mask;
   logic [6:0]    mask_nxt;
   logic [6:0]    mask_upd;

   logic          flag_prev;
   logic          req;
   logic          pending;
   logic          pending_nxt;
   logic [7:0]    dealt;

   logic          fifo_push;
   logic          fifo_pop;
   piece_id_t     fifo_head;
   piece_id_t     fifo_next;
   logic [CW-1:0] fifo_count;

   logic          unused_flag_bits;

   assign unused_flag_bits = ^generator_flag[7:1];

   // ---------------------------------------------------------------- LFSR
`ifdef PIECE_ENTROPY_MIX_EN
   logic [7:0] key_prev;

   always_ff @(posedge Clk) begin
      if (!Reset_n) key_prev <= 8'h00;
      else          key_prev <= keycode;
   end

   always_comb begin
      lfsr_mix = lfsr_step(lfsr);
      if ((keycode != key_prev) && (keycode != 8'h00)) begin
         lfsr_mix = lfsr_mix ^ {keycode, keycode};
      end
   end
`else
   logic unused_keycode;

   assign unused_keycode = ^keycode;

   always_comb begin
      lfsr_mix = lfsr_step(lfsr);
   end
`endif

   // An all-zero state would lock the LFSR, so reseed instead
   assign lfsr_nxt = (lfsr_mix == 16'h0000) ? SEED : lfsr_mix;

   always_ff @(posedge Clk) begin
      if (!Reset_n) lfsr <= SEED;
      else          lfsr <= lfsr_nxt;
   end

   assign random_noise = lfsr;

   // ---------------------------------------------------------- Filler FSM
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state <= FILL_IDLE;
         idx   <= PIECE_I;
         mask  <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         mask  <= mask_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      mask_nxt  = mask;
      mask_upd  = mask;
      fifo_push = 1'b0;
      case (state)
         FILL_IDLE: begin
            if (fifo_count != CW'(DEPTH)) state_nxt = FILL_PICK;
         end
         FILL_PICK: begin
            idx_nxt   = piece_id_t'(lfsr[7:0] % 8'd7);
            state_nxt = FILL_PROBE;
         end
         FILL_PROBE: begin
            // The mask is never full here, so the scan ends within six steps
            if (!mask[idx]) state_nxt = FILL_PUSH;
            else            idx_nxt   = (idx == PIECE_L) ? PIECE_I : idx + 3'd1;
         end
         FILL_PUSH: begin
            fifo_push = 1'b1;
            mask_upd  = mask | (7'b1 << idx);
            mask_nxt  = (mask_upd == BAG_FULL) ? '0 : mask_upd;
            state_nxt = FILL_IDLE;
         end
         default: state_nxt = FILL_IDLE;
      endcase
   end

   // ------------------------------------------------------ Request handling
   assign req = generator_flag[0] & ~flag_prev;

   // A pending request is served once a piece lands; new requests meanwhile are dropped
   always_comb begin
      fifo_pop    = 1'b0;
      pending_nxt = pending;
      if (pending) begin
         if (fifo_count != '0) begin
            fifo_pop    = 1'b1;
            pending_nxt = 1'b0;
         end
      end else if (req) begin
         if (fifo_count != '0) fifo_pop    = 1'b1;
         else                  pending_nxt = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         flag_prev <= 1'b0;
         pending   <= 1'b0;
         dealt     <= 8'h00;
      end else begin
         flag_prev <= generator_flag[0];
         pending   <= pending_nxt;
         if (fifo_pop) dealt <= dealt + 8'd1;
      end
   end

   piece_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .push      (fifo_push),
      .push_data (idx),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .next_data (fifo_next),
      .count     (fifo_count)
   );

   // -------------------------------------------------------------- Outputs
   assign piece_valid   = (fifo_count != '0);
   assign piece_id      = piece_valid ? fifo_head : PIECE_I;
   assign game_piece    = piece_valid ? piece_bitmap(fifo_head) : 16'h0000;
   assign next_piece_id = (fifo_count >= CW'(2)) ? fifo_next : PIECE_I;
   assign pieces_dealt  = dealt;

endmodule

// File: tb/tb_piece_bag_generator.sv
// Directed and randomized bench for piece_bag_generator against a queue-based
// behavioural model of the 7-bag generator and its LFSR.
module tb_piece_bag_generator;

   localparam int          DEPTH = 4;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic        Clk;
   logic        Reset_n;
   logic [7:0]  generator_flag;
   logic [7:0]  keycode;
   logic [15:0] game_piece;
   logic [2:0]  piece_id;
   logic [2:0]  next_piece_id;
   logic        piece_valid;
   logic [7:0]  pieces_dealt;
   logic [15:0] random_noise;

   int vectors;
   int miscompares;

   piece_bag_generator #(
      .DEPTH (DEPTH),
      .SEED  (SEED)
   ) dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .generator_flag (generator_flag),
      .keycode        (keycode),
      .game_piece     (game_piece),
      .piece_id       (piece_id),
      .next_piece_id  (next_piece_id),
      .piece_valid    (piece_valid),
      .pieces_dealt   (pieces_dealt),
      .random_noise   (random_noise)
   );

   // ------------------------------------------------ clock
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // ------------------------------------------------ reference model
   logic [15:0] rom [8] = '{16'h0F00, 16'h0660, 16'h04E0, 16'h06C0,
                            16'h0C60, 16'h08E0, 16'h02E0, 16'h0000};

   logic [2:0]  exp_q[$];      // expected preview FIFO contents, head first
   logic [2:0]  pop_log[$];    // heads handed out since reset, grouped by 7
   logic [15:0] m_lfsr;
   logic [6:0]  m_used;
   logic [7:0]  m_key_prev;
   bit          m_pending;
   bit          m_flag_prev;
   int          m_dealt;
   int          m_phase;       // 0 filler free, 1 about to pick, 2 counting down to push
   int          m_left;
   logic [2:0]  m_pick;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance the model across one rising edge using the inputs about to be sampled
   task automatic model_edge();
      logic [15:0] nx;
      logic [6:0]  gm;
      bit          do_pop;
      bit          do_push;
      bit          req;
      int          start;
      int          d;
      if (!Reset_n) begin
         m_lfsr      = SEED;
         m_used      = '0;
         m_key_prev  = 8'h00;
         m_pending   = 0;
         m_flag_prev = 0;
         m_dealt     = 0;
         m_phase     = 0;
         m_left      = 0;
         exp_q.delete();
         pop_log.delete();
         return;
      end
      nx = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
`ifdef PIECE_ENTROPY_MIX_EN
      if ((keycode != m_key_prev) && (keycode != 8'h00)) nx = nx ^ {keycode, keycode};
`endif
      if (nx == 16'h0000) nx = SEED;

      do_push = 0;
      case (m_phase)
         0: if (exp_q.size() < DEPTH) m_phase = 1;
         1: begin
            start = int'(m_lfsr[7:0]) % 7;
            d = 0;
            while (m_used[(start + d) % 7]) d++;
            m_pick  = 3'((start + d) % 7);
            m_left  = d + 2;
            m_phase = 2;
         end
         default: begin
            m_left--;
            if (m_left == 0) begin
               do_push = 1;
               m_phase = 0;
            end
         end
      endcase

      req    = generator_flag[0] && !m_flag_prev;
      do_pop = 0;
      if (m_pending) begin
         if (exp_q.size() > 0) begin
            do_pop    = 1;
            m_pending = 0;
         end
      end else if (req) begin
         if (exp_q.size() > 0) do_pop = 1;
         else                  m_pending = 1;
      end

      if (do_pop) begin
         pop_log.push_back(piece_id);
         void'(exp_q.pop_front());
         m_dealt = (m_dealt + 1) % 256;
         if (pop_log.size() == 7) begin
            gm = '0;
            foreach (pop_log[i]) gm = gm | (7'b1 << pop_log[i]);
            check("bag_group", 16'(gm), 16'h007F);
            pop_log.delete();
         end
      end
      if (do_push) begin
         exp_q.push_back(m_pick);
         m_used = m_used | (7'b1 << m_pick);
         if (m_used == 7'h7F) m_used = '0;
      end

      m_flag_prev = generator_flag[0];
      m_key_prev  = keycode;
      m_lfsr      = nx;
   endtask

   task automatic check_outputs();
      logic [2:0]  eh;
      logic [2:0]  en;
      logic [15:0] eg;
      eh = (exp_q.size() > 0) ? exp_q[0] : 3'd0;
      en = (exp_q.size() > 1) ? exp_q[1] : 3'd0;
      eg = (exp_q.size() > 0) ? rom[exp_q[0]] : 16'h0000;
      check("random_noise",  random_noise, m_lfsr);
      check("piece_valid",   16'(piece_valid), 16'(exp_q.size() > 0));
      check("piece_id",      16'(piece_id), 16'(eh));
      check("next_piece_id", 16'(next_piece_id), 16'(en));
      check("game_piece",    game_piece, eg);
      check("pieces_dealt",  16'(pieces_dealt), 16'(m_dealt));
   endtask

   task automatic tick();
      model_edge();
      @(posedge Clk);
      #1;
      check_outputs();
   endtask

   // ------------------------------------------------ stimulus
   initial begin
      logic [2:0]  first_head;
      logic [2:0]  first_next;
      logic [15:0] exp_noise;
      bit          found;

      vectors        = 0;
      miscompares    = 0;
      Reset_n        = 1'b0;
      generator_flag = 8'h00;
      keycode        = 8'h00;

      // Reset state
      tick();
      tick();
      check("reset_valid", 16'(piece_valid), 16'h0000);
      check("reset_noise", random_noise, SEED);
      check("reset_dealt", 16'(pieces_dealt), 16'h0000);
      Reset_n = 1'b1;

      // Free run after release: first piece on the 4th edge, FIFO fills
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (e == 3) check("valid_edge3", 16'(piece_valid), 16'h0000);
         if (e == 4) check("valid_edge4", 16'(piece_valid), 16'h0001);
      end
      first_head = exp_q[0];
      first_next = exp_q[1];

      // 14 spaced requests: two complete bags
      for (int i = 0; i < 14; i++) begin
         generator_flag = 8'h01;
         tick();
         generator_flag = 8'h00;
         repeat (9) tick();
      end
      check("dealt_after_14", 16'(pieces_dealt), 16'd14);

      // Burst from an empty FIFO: pending service and a dropped request
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         generator_flag = 8'h01;
         tick();
         generator_flag = 8'h00;
         tick();
      end
      repeat (40) tick();

      // Burst against a full FIFO
      for (int i = 0; i < 6; i++) begin
         generator_flag = 8'h01;
         tick();
         generator_flag = 8'h00;
         tick();
      end
      repeat (40) tick();

      // Reset while the filler is probing
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
      tick();
      tick();
      Reset_n = 1'b0;
      tick();
      check("probe_rst_valid", 16'(piece_valid), 16'h0000);
      check("probe_rst_piece", game_piece, 16'h0000);
      check("probe_rst_dealt", 16'(pieces_dealt), 16'h0000);
      Reset_n = 1'b1;
      repeat (40) tick();
      check("replay_head", 16'(piece_id), 16'(first_head));
      check("replay_next", 16'(next_piece_id), 16'(first_next));

      // Request landing on the same edge as a push with three entries queued
      generator_flag = 8'h01;
      tick();
      generator_flag = 8'h00;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (m_phase == 2 && m_left == 1 && exp_q.size() == 3) found = 1;
         else tick();
      end
      vectors++;
      assert (found) else begin
         miscompares++;
         $error("FAIL push_align: observed timeout expected push window");
      end
      generator_flag = 8'h01;
      tick();
      generator_flag = 8'h00;
      check("same_cycle_count3", 16'(exp_q.size()), 16'd3);
      check("same_cycle_next", 16'(next_piece_id), 16'(exp_q[1]));
      repeat (20) tick();

      // Keycode 0x00 -> 0x1A: mixed in only when the feature is built
      keycode = 8'h00;
      tick();
      exp_noise = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
`ifdef PIECE_ENTROPY_MIX_EN
      exp_noise = exp_noise ^ 16'h1A1A;
`endif
      if (exp_noise == 16'h0000) exp_noise = SEED;
      keycode = 8'h1A;
      tick();
      check("entropy_mix", random_noise, exp_noise);
      keycode = 8'h00;
      tick();

      // Randomized requests and keycodes
      for (int i = 0; i < 500; i++) begin
         generator_flag = {7'($urandom), 1'($urandom_range(0, 1))};
         if ($urandom_range(0, 7) == 0) keycode = 8'($urandom);
         tick();
      end
      generator_flag = 8'h00;
      repeat (10) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/piece_bag_generator.md
Name: piece_bag_generator

Overview:
- Hardware tetromino source feeding the SoC's piece, noise and generator PIO inputs; it sits directly upstream of the SoC.
- Generates pieces with a 7-bag randomizer driven by a free-running 16-bit LFSR.
- Keeps a DEPTH-entry preview FIFO full.
- Software requests the next piece through the generator flag and reads the head piece as a 4x4 bitmap.

Parameters:
- DEPTH, 4: preview FIFO entries; legal range 2..8.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- Clk  in  1  system clock (the only clock).
- Reset_n  in  1  synchronous, active-low reset.
- generator_flag  in  8  software request; only bit 0 is used, and a rising edge requests the next piece.
- keycode  in  8  keyboard keycode; used only when the optional feature is compiled in.
- game_piece  out  16  head piece bitmap, 4x4, row-major, bit15 = top-left.
- piece_id  out  3  head piece id: 0=I, 1=O, 2=T, 3=S, 4=Z, 5=J, 6=L.
- next_piece_id  out  3  FIFO entry behind the head (preview).
- piece_valid  out  1  FIFO non-empty; game_piece and piece_id are meaningful.
- pieces_dealt  out  8  count of accepted requests; wraps 255->0.
- random_noise  out  16  current LFSR state.

Behaviour:
- Clocking and reset
  - One clock; reset is synchronous and active-low.
  - Reset_n=0 at an edge: lfsr=SEED, FIFO empty, bag mask=0, FSM=IDLE, request pending=0, edge-detect register=0.
  - Reset output values: piece_valid=0, game_piece=0, piece_id=0, next_piece_id=0, pieces_dealt=0.
  - Reset mid-operation aborts any PICK/PROBE; nothing partial is pushed.
- LFSR
  - 16-bit Galois, advances every cycle: lfsr <= lfsr[0] ? (lfsr>>1)^16'hB400 : lfsr>>1.
  - random_noise = lfsr, registered.
  - If the next value would be 0, load SEED instead.
- Filler FSM (IDLE, PICK, PROBE, PUSH)
  - IDLE: if FIFO count < DEPTH, go to PICK; otherwise stay.
  - PICK: idx <= lfsr[7:0] mod 7; go to PROBE.
  - PROBE: if mask[idx]==0, go to PUSH; else idx <= (idx==6)?0:idx+1 and stay. At most 6 extra cycles, because the mask is never full here.
  - PUSH: write idx at FIFO tail; mask |= 1<<idx; if the result is 7'h7F, store mask=0 (bag refilled). Then go to IDLE.
  - Minimum 4 cycles per piece.
  - First piece_valid=1 on the 4th rising edge after reset release.
- Request handling
  - req = generator_flag[0] & ~prev.
  - FIFO non-empty: pop head and pieces_dealt++, both in the same cycle.
  - FIFO empty: set pending; the pop occurs in the cycle after the next PUSH.
  - A second request while pending is already set is dropped.
- Same-cycle pop and PUSH: both take effect; count is unchanged; the popped entry is the old head.
- FIFO full: FSM holds in IDLE; the LFSR keeps running.
- Outputs are registered from FIFO storage.
  - game_piece comes from ROM: I=16'h0F00, O=16'h0660, T=16'h04E0, S=16'h06C0, Z=16'h0C60, J=16'h08E0, L=16'h02E0.
  - When empty, game_piece=0 and piece_id=0.
  - next_piece_id=0 when count<2.
- Bag guarantee: every aligned group of 7 pushes after reset contains each id exactly once.

Optional Feature:
- Macro: PIECE_ENTROPY_MIX_EN.
- Defined: on any cycle where keycode differs from its registered previous value and is nonzero, the LFSR next value is XORed with {keycode, keycode}. The zero-guard still applies.
- Undefined: keycode is ignored, and the sequence after reset is fully deterministic from SEED.
- The port list is identical in both builds.

Decomposition:
- Package polytris_pkg:
  - typedef piece_id_t (logic [2:0]) and enum constants PIECE_I..PIECE_L.
  - PIECE_ROM bitmap constant array.
  - LFSR_TAPS = 16'hB400.
  - BAG_FULL = 7'h7F.
- One natural sub-module: piece_fifo, a parameterised DEPTH x 3-bit synchronous FIFO with same-cycle push/pop and head/next read ports.
- LFSR and FSM stay in the top module.

Test Plan:
- Reset with SEED=16'hACE1, no requests: piece_valid rises on the 4th edge; the FIFO fills to 4; random_noise matches the Galois model every cycle.
- 14 requests spaced 10 cycles apart: pieces 1-7 and 8-14 are each permutations of 0..6; pieces_dealt=14; each game_piece equals the ROM value for its piece_id.
- Burst of 6 requests on alternating cycles with DEPTH=4:
  - Empty-FIFO requests are served through pending.
  - The request arriving while pending is already set is dropped.
  - pieces_dealt counts only accepted requests.
  - piece_valid never shows stale data.
- Reset_n asserted during PROBE, held 1 cycle: all outputs return to 0 next edge; the post-reset piece sequence is identical to the first test.
- Request arriving in the same cycle as PUSH with count=3: head pops, new tail is written, count stays 3, next_piece_id is updated.
- PIECE_ENTROPY_MIX_EN defined, keycode 0x00->0x1A: LFSR next value is the model XOR 16'h1A1A; with the macro undefined, the sequence is unchanged.
